// File: rtl/imem_loadable.sv
// Word-organised instruction memory: sequential clear after reset, byte-stream program load, registered fetch port.
// Fetch latency 1 cycle; the loader is always ready in LOAD (overflow bytes are dropped), and fetch_stall holds the fetch outputs.
module imem_loadable #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_start_i,
  input  logic                  ld_byte_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_byte_last_i,
  output logic                  ld_byte_ready_o,
  output logic                  load_done_o,
  output logic [ADDR_WIDTH-2:0] load_words_o,
  output logic                  load_overflow_o,
  output logic                  busy_o,
  input  logic                  fetch_en_i,
  input  logic                  fetch_stall_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic [31:0]           instruction_o,
  output logic                  instr_valid_o,
  output logic                  fetch_misaligned_o
);
  localparam int WAW   = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WAW;
  localparam logic [WAW-1:0]        LAST_WORD  = WAW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-2:0] FULL_COUNT = (ADDR_WIDTH-1)'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_DONE} state_e;

  state_e                state_q;
  logic [WAW-1:0]        clr_ptr_q;
  logic [1:0]            lane_q;
  logic [23:0]           asm_q;
  logic [ADDR_WIDTH-2:0] load_words_q;
  logic                  overflow_q;
  logic [31:0]           instr_q;
  logic                  instr_vld_q;
  logic                  misaligned_q;
  logic [31:0]           mem_q [DEPTH];

  logic           restart;
  logic           byte_acc;
  logic           full;
  logic           word_done;
  logic [31:0]    word_d;
  logic           mem_we;
  logic [WAW-1:0] mem_waddr;
  logic [31:0]    mem_wdata;
  logic           fetch_ok;
  logic           misaligned_d;

  assign restart   = (state_q == S_LOAD) && load_start_i;
  assign byte_acc  = (state_q == S_LOAD) && ld_byte_valid_i && !load_start_i;
  assign full      = (load_words_q == FULL_COUNT);
  assign word_done = byte_acc && ((lane_q == 2'd3) || ld_byte_last_i);

  // Incoming byte merged into the partial word; lanes above it are zero.
  always_comb begin
    word_d = 32'h0;
    case (lane_q)
      2'd0:    word_d = {24'h0, ld_byte_i};
      2'd1:    word_d = {16'h0, ld_byte_i, asm_q[7:0]};
      2'd2:    word_d = {8'h0, ld_byte_i, asm_q[15:0]};
      default: word_d = {ld_byte_i, asm_q};
    endcase
  end

  assign mem_we    = (state_q == S_CLEAR) || (word_done && !full);
  assign mem_waddr = (state_q == S_CLEAR) ? clr_ptr_q : load_words_q[WAW-1:0];
  assign mem_wdata = (state_q == S_CLEAR) ? 32'h0 : word_d;

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      lane_q       <= 2'd0;
      asm_q        <= 24'h0;
      load_words_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_WORD) state_q <= S_IDLE;
        end
        S_IDLE, S_DONE: begin
          if (load_start_i) begin
            state_q      <= S_LOAD;
            lane_q       <= 2'd0;
            load_words_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        default: begin
          if (restart) begin
            lane_q       <= 2'd0;
            load_words_q <= '0;
            overflow_q   <= 1'b0;
          end else if (byte_acc) begin
            if (full) overflow_q <= 1'b1;
            else if (word_done) load_words_q <= load_words_q + 1'b1;
            case (lane_q)
              2'd0:    asm_q[7:0]   <= ld_byte_i;
              2'd1:    asm_q[15:8]  <= ld_byte_i;
              2'd2:    asm_q[23:16] <= ld_byte_i;
              default: asm_q        <= asm_q;
            endcase
            lane_q <= ld_byte_last_i ? 2'd0 : lane_q + 1'b1;
            if (ld_byte_last_i) state_q <= S_DONE;
          end
        end
      endcase
    end
  end

  assign fetch_ok     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign misaligned_d = (fetch_addr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i) begin
    if (reset_i || !fetch_ok) begin
      instr_q      <= 32'h0;
      instr_vld_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (fetch_stall_i) begin
      instr_q      <= instr_q;
      instr_vld_q  <= instr_vld_q;
      misaligned_q <= misaligned_q;
    end else if (fetch_en_i) begin
      instr_q      <= misaligned_d ? 32'h0 : mem_q[fetch_addr_i[ADDR_WIDTH-1:2]];
      instr_vld_q  <= 1'b1;
      misaligned_q <= misaligned_d;
    end else begin
      instr_q      <= 32'h0;
      instr_vld_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end
  end

  assign ld_byte_ready_o    = (state_q == S_LOAD);
  assign busy_o             = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign load_done_o        = (state_q == S_DONE);
  assign load_words_o       = load_words_q;
  assign load_overflow_o    = overflow_q;
  assign instruction_o      = instr_q;
  assign instr_valid_o      = instr_vld_q;
  assign fetch_misaligned_o = misaligned_q;
endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: randomized byte-stream loads and fetches checked against an array/queue reference model.
module tb_imem_loadable;
  localparam int AW    = 10;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset, load_start, ld_byte_valid, ld_byte_last;
  logic [7:0]    ld_byte;
  logic          ld_byte_ready, load_done, load_overflow, busy;
  logic [AW-2:0] load_words;
  logic          fetch_en, fetch_stall;
  logic [AW-1:0] fetch_addr;
  logic [31:0]   instruction;
  logic          instr_valid, fetch_misaligned;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  cur_q [$];

  always #5 clk = ~clk;

  imem_loadable #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_i(reset), .load_start_i(load_start),
    .ld_byte_valid_i(ld_byte_valid), .ld_byte_i(ld_byte), .ld_byte_last_i(ld_byte_last),
    .ld_byte_ready_o(ld_byte_ready), .load_done_o(load_done), .load_words_o(load_words),
    .load_overflow_o(load_overflow), .busy_o(busy),
    .fetch_en_i(fetch_en), .fetch_stall_i(fetch_stall), .fetch_addr_i(fetch_addr),
    .instruction_o(instruction), .instr_valid_o(instr_valid), .fetch_misaligned_o(fetch_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    cur_q.delete();
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) step();
    ld_byte_valid = 1'b1;
    ld_byte       = b;
    ld_byte_last  = last;
    step();
    ld_byte_valid = 1'b0;
    ld_byte_last  = 1'b0;
    cur_q.push_back(b);
  endtask

  // Fold the bytes of the current load into the model; returns the expected word count.
  task automatic commit(input bit finished, output int nw);
    int n;
    logic [31:0] w;
    n  = cur_q.size();
    nw = finished ? (n + 3) / 4 : n / 4;
    if (nw > DEPTH) nw = DEPTH;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < n) w = w | (32'(cur_q[4 * i + k]) << (8 * k));
      ref_mem[i] = w;
    end
  endtask

  task automatic fetch_chk(input string tag, input logic [AW-1:0] a);
    logic [7:0] wi;
    fetch_en   = 1'b1;
    fetch_addr = a;
    step();
    fetch_en = 1'b0;
    wi = a[AW-1:2];
    chk({tag, "_vld"}, instr_valid, 1);
    chk({tag, "_mis"}, fetch_misaligned, (a[1:0] != 2'b00) ? 1 : 0);
    chk({tag, "_dat"}, instruction, (a[1:0] != 2'b00) ? 32'h0 : ref_mem[wi]);
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    if (busy) chk({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nw, len;
    bit vld_in_clear;
    logic [31:0] held_i, held_v, held_m;
    logic [7:0] dirb [6];
    logic [7:0] ovb;

    reset = 1'b1; load_start = 1'b0; ld_byte_valid = 1'b0; ld_byte_last = 1'b0;
    ld_byte = 8'h0; fetch_en = 1'b0; fetch_stall = 1'b0; fetch_addr = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    step(); step();
    chk("rst_instr", instruction, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_mis", fetch_misaligned, 0);
    chk("rst_words", load_words, 0);
    chk("rst_ovf", load_overflow, 0);
    chk("rst_done", load_done, 0);
    chk("rst_rdy", ld_byte_ready, 0);
    chk("rst_busy", busy, 1);

    // Clear engine: fetch held requested throughout, must be ignored until IDLE.
    reset = 1'b0; fetch_en = 1'b1; fetch_addr = 10'h3FC;
    n = 0; vld_in_clear = 0;
    while (busy && n < 2000) begin
      step();
      n++;
      if (busy && instr_valid) vld_in_clear = 1;
    end
    chk("clear_cycles", n, 256);
    chk("clear_no_fetch", vld_in_clear, 0);
    step();
    fetch_en = 1'b0;
    chk("f3fc_vld", instr_valid, 1);
    chk("f3fc_dat", instruction, 0);

    // Directed program.
    start_load();
    chk("ld_rdy", ld_byte_ready, 1);
    chk("ld_busy", busy, 1);
    dirb = '{8'h13, 8'h00, 8'h10, 8'h20, 8'hEF, 8'hBE};
    for (int i = 0; i < 6; i++) send(dirb[i], i == 5);
    commit(1, nw);
    chk("dir_words", load_words, 2);
    chk("dir_done", load_done, 1);
    chk("dir_busy", busy, 0);
    chk("dir_ovf", load_overflow, 0);
    chk("dir_w0_model", ref_mem[0], 32'h20100013);
    fetch_chk("dir_f0", 10'h000);
    chk("dir_w0_lit", instruction, 32'h20100013);
    fetch_chk("dir_f4", 10'h004);
    chk("dir_w1_lit", instruction, 32'h0000BEEF);
    fetch_chk("dir_f2", 10'h002);

    // Stall holds outputs while the request lines move.
    fetch_chk("stall_pre", 10'h004);
    held_i = instruction; held_v = instr_valid; held_m = fetch_misaligned;
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_en   = 1'($urandom);
      fetch_addr = AW'($urandom);
      step();
      chk("stall_instr", instruction, 32'h0000BEEF);
      chk("stall_vld", instr_valid, held_v);
      chk("stall_mis", fetch_misaligned, held_m);
    end
    fetch_stall = 1'b0; fetch_en = 1'b0;
    step();
    chk("idle_vld", instr_valid, 0);
    chk("idle_instr", instruction, 0);

    // load_start together with a fetch: fetch completes, state enters LOAD.
    fetch_en = 1'b1; fetch_addr = 10'h000; load_start = 1'b1;
    step();
    load_start = 1'b0;
    cur_q.delete();
    chk("ls_fetch_dat", instruction, ref_mem[0]);
    chk("ls_fetch_vld", instr_valid, 1);
    chk("ls_rdy", ld_byte_ready, 1);
    step();
    fetch_en = 1'b0;
    chk("load_nofetch", instr_valid, 0);

    // Randomized loads of varied length, each followed by random fetches.
    for (int r = 0; r < 5; r++) begin
      if (r > 0) start_load();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) send(8'($urandom), i == len - 1);
      commit(1, nw);
      chk("rnd_words", load_words, nw);
      chk("rnd_done", load_done, 1);
      chk("rnd_ovf", load_overflow, 0);
      for (int f = 0; f < 6; f++) begin
        if (f[0]) fetch_chk("rnd_f", AW'($urandom_range(0, 4 * nw + 8)));
        else      fetch_chk("rnd_f", AW'($urandom));
      end
    end

    // Overflow: 257 words streamed.
    start_load();
    for (int i = 0; i < 1028; i++) send(8'($urandom), i == 1027);
    commit(1, nw);
    chk("ovf_words", load_words, 256);
    chk("ovf_flag", load_overflow, 1);
    chk("ovf_done", load_done, 1);
    fetch_chk("ovf_f0", 10'h000);
    fetch_chk("ovf_f3fc", 10'h3FC);

    // Restart after 6 bytes.
    start_load();
    chk("re_ovf_clr", load_overflow, 0);
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b0);
    commit(0, nw);
    chk("re_words6", load_words, 1);
    start_load();
    chk("re_words0", load_words, 0);
    chk("re_rdy", ld_byte_ready, 1);

    // Restart while overflowed, then a small load.
    for (int i = 0; i < 1030; i++) begin
      ovb = 8'($urandom);
      send(ovb, 1'b0);
    end
    commit(0, nw);
    chk("re2_ovf", load_overflow, 1);
    chk("re2_words", load_words, 256);
    start_load();
    chk("re2_ovf_clr", load_overflow, 0);
    chk("re2_words0", load_words, 0);
    send(8'hDD, 1'b0); send(8'hCC, 1'b0); send(8'hBB, 1'b0); send(8'hAA, 1'b1);
    commit(1, nw);
    chk("re2_words1", load_words, 1);
    fetch_chk("re2_f0", 10'h000);
    chk("re2_w0_lit", instruction, 32'hAABBCCDD);
    fetch_chk("re2_f4", 10'h004);

    // Reset mid-load: memory cleared again, load_start ignored during CLEAR.
    start_load();
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("rc_rdy", ld_byte_ready, 0);
    chk("rc_busy", busy, 1);
    chk("rc_words", load_words, 0);
    wait_idle("rc", n);
    chk("rc_idle_rdy", ld_byte_ready, 0);
    chk("rc_idle_done", load_done, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    fetch_chk("rc_f0", 10'h000);
    fetch_chk("rc_f4", 10'h004);
    for (int f = 0; f < 3; f++) fetch_chk("rc_fr", AW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised instruction memory for the IF stage, the successor to the fixed 256-byte instruction store. It is word-organised with a configurable depth, so it does not clear the whole array combinationally on reset; a sequential clear engine runs instead. It takes its program from the debug unit as a byte stream over a valid/ready handshake and packs it into little-endian words. It serves fetches through a registered read port with stall and misalignment detection.

## Interface
- ADDR_WIDTH, 10, byte-address width; memory holds DEPTH = 2^(ADDR_WIDTH-2) 32-bit words
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle pulse: begin a new program load at word 0
- ld_byte_valid  in  1  loader byte present
- ld_byte  in  8  loader byte, little-endian order within each word
- ld_byte_last  in  1  qualifies final byte of program (sampled with valid&ready)
- ld_byte_ready  out  1  block accepts a byte this cycle
- load_done  out  1  program loaded, fetch enabled
- load_words  out  ADDR_WIDTH-1  number of words written by last/current load
- load_overflow  out  1  sticky: bytes arrived beyond DEPTH words
- busy  out  1  clear or load in progress
- fetch_en  in  1  fetch request
- fetch_stall  in  1  hold fetch outputs (priority over fetch_en)
- fetch_addr  in  ADDR_WIDTH  byte address of instruction
- instruction  out  32  fetched word
- instr_valid  out  1  instruction holds a fetch result
- fetch_misaligned  out  1  fetch_addr[1:0] was nonzero for the held result

## Operation
- States: CLEAR, IDLE, LOAD, DONE.
- Reset enters CLEAR with clear pointer = 0. One word is zeroed per cycle. After word DEPTH-1 is zeroed, the state goes to IDLE.
- IDLE/DONE: load_start goes to LOAD. load_start is ignored in CLEAR.
- LOAD:
  - On entry, write pointer = 0, byte lane = 0, load_words = 0, and load_overflow is cleared.
  - A byte is accepted when ld_byte_valid && ld_byte_ready. It lands in lane 0..3 of the assembly register.
  - When lane 3 is accepted, the word is written at the write pointer on that edge. The pointer increments and load_words increments.
  - If ld_byte_last is accepted on lane <3, the unfilled upper lanes are zero and the word is written on that edge.
  - Acceptance of ld_byte_last moves the state to DONE.
  - If the pointer has already written word DEPTH-1, further bytes are still accepted (ready stays 1) but discarded, and load_overflow is set.
  - load_start in LOAD restarts the load: pointer, lane, load_words and overflow are reset, and any partial word is discarded.
- Fetch is serviced only in IDLE and DONE. In CLEAR and LOAD, requests are ignored and instr_valid = 0.
- Fetch handling, evaluated each cycle:
  - fetch_stall = 1: all fetch outputs hold.
  - fetch_en = 1: instruction <= mem[fetch_addr[ADDR_WIDTH-1:2]], instr_valid <= 1, fetch_misaligned <= (fetch_addr[1:0] != 0). A misaligned fetch returns instruction = 0.
  - Neither: instruction <= 0, instr_valid <= 0, fetch_misaligned <= 0.
- ld_byte_ready = (state == LOAD). busy = (state == CLEAR || state == LOAD). load_done = (state == DONE).

## Timing
- Reset values: instruction = 0, instr_valid = 0, fetch_misaligned = 0, load_words = 0, load_overflow = 0, load_done = 0, ld_byte_ready = 0, busy = 1.
- CLEAR lasts exactly DEPTH cycles after reset deasserts. With ADDR_WIDTH=10 that is 256 cycles; busy falls on the following cycle.
- Fetch latency is 1 cycle: the address is sampled at edge N and instruction is valid after edge N.
- Load write is visible to a fetch issued at the earliest cycle DONE is reached. No read-during-write case exists, because fetch is gated outside IDLE/DONE.
- load_start to ld_byte_ready = 1: 1 cycle.
- reset mid-load or mid-clear restarts CLEAR from word 0; a partial load is lost.
- Simultaneous load_start and fetch_en in IDLE/DONE: the fetch completes on that edge and the state enters LOAD.

## Test plan
- Reset with ADDR_WIDTH=10, then fetch 0x3FC: busy = 1 for 256 cycles, then the fetch returns 0x00000000 with instr_valid = 1.
- Load bytes 0x13,0x00,0x10,0x20, then 0xEF,0xBE (last) -> load_words = 2, load_done = 1. Fetch 0x000 -> 0x20100013. Fetch 0x004 -> 0x0000BEEF.
- Fetch 0x002 after load -> instruction = 0, fetch_misaligned = 1, instr_valid = 1.
- Hold fetch_stall = 1 for 3 cycles while fetch_addr changes -> instruction, instr_valid and fetch_misaligned are unchanged.
- Stream 257 words at ADDR_WIDTH=10 -> load_overflow = 1 and load_words = 256. Word 0 keeps its first value.
- Assert load_start after 6 bytes of a load -> load_words = 0 and overflow is cleared. A new 4-byte load of 0xAABBCCDD written as bytes DD,CC,BB,AA (last) puts 0xAABBCCDD at word 0.
